// File: rtl/bus_mux_pipe_if.sv
// Bus multiplexer interface: source words and drive enables in, registered bus and debug status out.
interface bus_mux_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 24,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_en;
  logic                  stall;
  logic                  clr_err;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [SELW-1:0]       bus_src;
  logic                  conflict;
  logic [CNT_W-1:0]      conflict_cnt;

  modport master (
    output src_data, src_en, stall, clr_err,
    input  bus_out, bus_valid, bus_src, conflict, conflict_cnt
  );

  modport slave (
    input  src_data, src_en, stall, clr_err,
    output bus_out, bus_valid, bus_src, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_mux_pipe.sv
// Registered fixed-priority datapath bus multiplexer driven by one-hot enables,
// with multi-driver conflict detection and a saturating conflict counter.
module bus_mux_pipe #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NSRC      = 24,
  parameter int unsigned IDLE_ZERO = 0,
  parameter int unsigned CNT_W     = 8
) (
  input logic         clk,
  input logic         rst_n,
  bus_mux_pipe_if.slave bus
);
  localparam int unsigned SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [WIDTH-1:0] bus_q;
  logic             valid_q;
  logic [SELW-1:0]  src_q;
  logic             conflict_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] win_data;
  logic [SELW-1:0]  win_idx;
  logic             any_en;
  logic             multi_en;

  // Lowest set enable wins: scan downward so the last hit is the lowest index.
  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (bus.src_en[i]) begin
        win_data = bus.src_data[i*WIDTH +: WIDTH];
        win_idx  = SELW'(i);
      end
    end
    any_en   = |bus.src_en;
    multi_en = |(bus.src_en & (bus.src_en - NSRC'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q      <= '0;
      valid_q    <= 1'b0;
      src_q      <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else if (!bus.stall) begin
      valid_q    <= any_en;
      conflict_q <= multi_en;
      if (any_en) begin
        bus_q <= win_data;
        src_q <= win_idx;
      end else if (IDLE_ZERO != 0) begin
        bus_q <= '0;
      end
      // Clear has priority over a coincident conflict increment.
      if (bus.clr_err) begin
        cnt_q <= '0;
      end else if (multi_en && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.bus_out      = bus_q;
  assign bus.bus_valid    = valid_q;
  assign bus.bus_src      = src_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: doc/bus_mux_pipe.md
Name: bus_mux_pipe

Overview:
Parametrised, registered successor to the datapath bus multiplexer. It selects one of NSRC source words onto the shared WIDTH-bit datapath bus from one-hot drive enables (Rout/PCout/MDRout-style), with no external encoder. It registers the result and reports which source drove the bus. It also detects multi-driver conflicts and keeps a saturating conflict count for debug. It sits between the register file and special registers and the bus consumers (ALU Y/MAR/MDR inputs).

Parameters:
WIDTH, 32, bus word width in bits
NSRC, 24, number of bus sources (2..32)
IDLE_ZERO, 0, behaviour when no enable is asserted: 0 = hold last bus value, 1 = drive zero
CNT_W, 8, width of the saturating conflict counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
src_data  input  NSRC*WIDTH  flattened source words; source i occupies bits [i*WIDTH +: WIDTH]
src_en  input  NSRC  drive enables, intended one-hot; bit i requests source i
stall  input  1  when 1, all state is frozen
clr_err  input  1  synchronous clear of conflict_cnt
bus_out  output  WIDTH  registered bus value
bus_valid  output  1  1 when bus_out was driven by a source on the previous accepted cycle
bus_src  output  SELW  index of the source that drove bus_out; SELW = max(1, clog2(NSRC)), a localparam
conflict  output  1  one-cycle registered flag: more than one enable was set on the previous accepted cycle
conflict_cnt  output  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset (rst_n = 0, asynchronous): bus_out = 0, bus_valid = 0, bus_src = 0, conflict = 0, conflict_cnt = 0. Reset takes effect immediately mid-operation. No partial state survives.
- Latency: the enables and data sampled at rising edge k appear on the outputs after edge k. This is a single register stage.
- Accepted cycle: a rising edge with rst_n = 1 and stall = 0. On stall = 1, every register (including conflict_cnt) holds, and clr_err is ignored.
- Selection on an accepted cycle:
  - Winner = lowest index i with src_en[i] = 1 (fixed priority).
  - bus_out <= src_data[winner]; bus_src <= winner; bus_valid <= 1.
- Idle (src_en = 0) on an accepted cycle:
  - bus_valid <= 0; bus_src holds.
  - bus_out holds if IDLE_ZERO = 0 and is set to 0 if IDLE_ZERO = 1.
- Conflict (popcount(src_en) >= 2) on an accepted cycle:
  - The bus is still driven by the priority winner.
  - conflict <= 1; otherwise conflict <= 0.
  - conflict_cnt increments by 1 and saturates at 2^CNT_W-1. It never wraps.
- clr_err on an accepted cycle: conflict_cnt <= 0. If clr_err coincides with a conflict, clear wins and the count is 0. The conflict flag is still set.
- src_en bits at or above NSRC do not exist. src_data beyond NSRC*WIDTH is not referenced.
- No combinational path from inputs to outputs.
- No latches: every branch assigns all next-state values.

Test Plan:
- Reset: assert rst_n = 0 asynchronously between clock edges with a nonzero bus -> all outputs 0 immediately. Release -> first accepted cycle with src_en = 1<<3 and src 3 = 0xDEADBEEF gives bus_out = 0xDEADBEEF, bus_src = 3, bus_valid = 1 one edge later.
- Sweep: drive each src_en = 1<<i, i = 0..23, with src i = 0x1000_0000 + i -> bus_out = 0x1000_0000 + i and bus_src = i one cycle later. conflict stays 0 and conflict_cnt = 0 throughout.
- Conflict: src_en = (1<<5)|(1<<20) -> bus_src = 5, conflict = 1 for exactly one cycle, conflict_cnt = 1. Repeat for 300 cycles with CNT_W = 8 -> conflict_cnt saturates at 255. Then clr_err -> conflict_cnt = 0.
- Idle: after driving 0x12345678, set src_en = 0 -> bus_valid = 0 and bus_out = 0x12345678 with IDLE_ZERO = 0. Rerun with IDLE_ZERO = 1 -> bus_out = 0 on the next edge. In both builds bus_src is unchanged.
- Stall: stall = 1 for 3 cycles while src_en changes and clr_err = 1 -> outputs and conflict_cnt frozen. On release, the next edge reflects the inputs present at that edge.
- Parametrisation: build with WIDTH = 16, NSRC = 4. Driving src_en = 4'b1100 -> bus_src = 2, conflict = 1, and bus_out equals the 16-bit word of source 2.
